// File: rtl/shift_engine.sv
// WIDTH-bit shift/rotate register with a start/busy/done handshake.
// Define SHIFT_ENGINE_BARREL_EN for single-cycle barrel shifts.
module shift_engine #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   amount,
    input  logic [WIDTH-1:0] din,
    input  logic             serial_in,
    output logic [WIDTH-1:0] dout,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_SET   = 3'b000;
    localparam logic [2:0] OP_SHL   = 3'b001;
    localparam logic [2:0] OP_ROL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_SAR   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_LOAD  = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic             so_q, so_d;
    logic             done_q, done_d;

`ifdef SHIFT_ENGINE_BARREL_EN
    // Result is {serial_out, reg}; n is nonzero here.
    function automatic logic [WIDTH:0] barrel(
        input logic [2:0]       o,
        input logic [WIDTH-1:0] v,
        input logic [SHW-1:0]   n,
        input logic             si,
        input logic             so
    );
        logic [WIDTH:0]     lw;
        logic [WIDTH:0]     rw;
        logic [2*WIDTH-1:0] wl;
        logic [2*WIDTH-1:0] wr;
        logic [WIDTH-1:0]   fill;
        logic [WIDTH-1:0]   sar;
        logic [WIDTH:0]     r;
        lw   = {1'b0, v} << n;
        rw   = {v, 1'b0} >> n;
        wl   = {v, v} << n;
        wr   = {v, v} >> n;
        fill = si ? ~({WIDTH{1'b1}} << n) : '0;
        sar  = $signed(v) >>> n;
        r    = {so, v};
        unique case (o)
            OP_SHL:  r = {lw[WIDTH], lw[WIDTH-1:0] | fill};
            OP_ROL:  r = {so, wl[2*WIDTH-1:WIDTH]};
            OP_SHR:  r = {rw[0], rw[WIDTH:1]};
            OP_SAR:  r = {rw[0], sar};
            OP_ROR:  r = {so, wr[WIDTH-1:0]};
            default: r = {so, v};
        endcase
        return r;
    endfunction
`else
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [2:0]     op_q, op_d;

    // Single bit step; result is {serial_out, reg}.
    function automatic logic [WIDTH:0] step(
        input logic [2:0]       o,
        input logic [WIDTH-1:0] v,
        input logic             si,
        input logic             so
    );
        logic [WIDTH:0] r;
        r = {so, v};
        unique case (o)
            OP_SHL:  r = {v[WIDTH-1], v[WIDTH-2:0], si};
            OP_ROL:  r = {so, v[WIDTH-2:0], v[WIDTH-1]};
            OP_SHR:  r = {v[0], 1'b0, v[WIDTH-1:1]};
            OP_SAR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROR:  r = {so, v[0], v[WIDTH-1:1]};
            default: r = {so, v};
        endcase
        return r;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        so_d    = so_q;
        done_d  = 1'b0;
`ifndef SHIFT_ENGINE_BARREL_EN
        cnt_d   = cnt_q;
        op_d    = op_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    unique case (op)
                        OP_SET: begin
                            reg_d  = '1;
                            done_d = 1'b1;
                        end
                        OP_LOAD: begin
                            reg_d  = din;
                            done_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            reg_d  = '0;
                            done_d = 1'b1;
                        end
                        default: begin
                            if (amount == '0) begin
                                done_d = 1'b1;
                            end else begin
`ifdef SHIFT_ENGINE_BARREL_EN
                                {so_d, reg_d} = barrel(op, reg_q, amount,
                                                       serial_in, so_q);
                                done_d = 1'b1;
`else
                                {so_d, reg_d} = step(op, reg_q,
                                                     serial_in, so_q);
                                cnt_d = amount - 1'b1;
                                op_d  = op;
                                if (cnt_d == '0) done_d = 1'b1;
                                else state_d = SHIFT;
`endif
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
`ifdef SHIFT_ENGINE_BARREL_EN
                state_d = IDLE;
`else
                {so_d, reg_d} = step(op_q, reg_q, serial_in, so_q);
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            reg_q   <= '0;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
`ifndef SHIFT_ENGINE_BARREL_EN
            cnt_q   <= '0;
            op_q    <= OP_SET;
`endif
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            so_q    <= so_d;
            done_q  <= done_d;
`ifndef SHIFT_ENGINE_BARREL_EN
            cnt_q   <= cnt_d;
            op_q    <= op_d;
`endif
        end
    end

    assign dout       = reg_q;
    assign serial_out = so_q;
    assign busy       = (state_q == SHIFT);
    assign done       = done_q;

endmodule

// File: tb/tb_shift_engine.sv
// Directed self-checking bench for shift_engine (WIDTH=8).
// Honours SHIFT_ENGINE_BARREL_EN for latency expectations.
module tb_shift_engine;

    localparam logic [2:0] SET   = 3'b000;
    localparam logic [2:0] SHL   = 3'b001;
    localparam logic [2:0] ROL   = 3'b010;
    localparam logic [2:0] SHR   = 3'b011;
    localparam logic [2:0] SAR   = 3'b100;
    localparam logic [2:0] ROR   = 3'b101;
    localparam logic [2:0] LOAD  = 3'b110;
    localparam logic [2:0] CLEAR = 3'b111;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [2:0] amount;
    logic [7:0] din;
    logic       serial_in;
    logic [7:0] dout;
    logic       serial_out;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    int n;
    int bc;
    logic seen;

    shift_engine #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .amount     (amount),
        .din        (din),
        .serial_in  (serial_in),
        .dout       (dout),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input logic [2:0] o, input logic [2:0] a);
`ifdef SHIFT_ENGINE_BARREL_EN
        return 0;
`else
        if (o inside {SHL, ROL, SHR, SAR, ROR} && a != 3'd0)
            return int'(a) - 1;
        return 0;
`endif
    endfunction

    // Issue one op; returns just after the edge where done is seen.
    task automatic run(input logic [2:0] o, input logic [2:0] a,
                       input logic [7:0] d, input logic si);
        @(negedge clk);
        start = 1'b1; op = o; amount = a; din = d; serial_in = si;
        @(posedge clk); #1;
        start = 1'b0;
        n  = 0;
        bc = int'(busy);
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            bc += int'(busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = SET; amount = 3'd0;
        din = 8'h00; serial_in = 1'b0;
        #1;
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_so",   32'(serial_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run(LOAD, 3'd0, 8'hA5, 1'b0);
        chk("load_a5", 32'(dout), 32'hA5);
        chk("load_lat", 32'(n), 32'd0);

        run(SHL, 3'd3, 8'h00, 1'b1);
        chk("shl3_dout", 32'(dout), 32'h2F);
        chk("shl3_so", 32'(serial_out), 32'd1);
        chk("shl3_lat", 32'(n), 32'(lat(SHL, 3'd3)));
        chk("shl3_busy", 32'(bc), 32'(lat(SHL, 3'd3)));
        @(posedge clk); #1;
        chk("done_pulse", 32'(done), 32'd0);

        run(LOAD, 3'd0, 8'h90, 1'b0);
        chk("load_90", 32'(dout), 32'h90);
        chk("load_so_hold", 32'(serial_out), 32'd1);
        run(SAR, 3'd2, 8'h00, 1'b0);
        chk("sar2_b2b_lat", 32'(n), 32'(lat(SAR, 3'd2)));
        chk("sar2_dout", 32'(dout), 32'hE4);
        chk("sar2_so", 32'(serial_out), 32'd0);
        run(SHR, 3'd4, 8'h00, 1'b0);
        chk("shr4_dout", 32'(dout), 32'h0E);
        chk("shr4_so", 32'(serial_out), 32'd0);
        chk("shr4_lat", 32'(n), 32'(lat(SHR, 3'd4)));

        run(LOAD, 3'd0, 8'h81, 1'b0);
        run(ROR, 3'd1, 8'h00, 1'b0);
        chk("ror1_dout", 32'(dout), 32'hC0);
        chk("ror1_so", 32'(serial_out), 32'd0);
        run(ROL, 3'd4, 8'h00, 1'b0);
        chk("rol4_dout", 32'(dout), 32'h0C);
        chk("rol4_lat", 32'(n), 32'(lat(ROL, 3'd4)));

`ifdef SHIFT_ENGINE_BARREL_EN
        run(SHL, 3'd7, 8'h00, 1'b1);
        chk("shl7_lat", 32'(n), 32'd0);
`else
        @(negedge clk);
        start = 1'b1; op = SHL; amount = 3'd7; serial_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = CLEAR;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_at_clear", 32'(busy), 32'd1);
        n = 3;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("shl7_lat", 32'(n), 32'd6);
`endif
        chk("shl7_dout", 32'(dout), 32'h7F);
        chk("shl7_so", 32'(serial_out), 32'd0);

        run(ROL, 3'd0, 8'h00, 1'b0);
        chk("rol0_dout", 32'(dout), 32'h7F);
        chk("rol0_done", 32'(done), 32'd1);
        chk("rol0_lat", 32'(n), 32'd0);

        run(SET, 3'd0, 8'h00, 1'b0);
        chk("set_dout", 32'(dout), 32'hFF);

        @(negedge clk);
        start = 1'b1; op = SHL; amount = 3'd5; serial_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`ifdef SHIFT_ENGINE_BARREL_EN
        chk("shl5_mid", 32'(dout), 32'hE0);
`else
        chk("shl5_mid", 32'(dout), 32'hF8);
`endif
        rst = 1'b1;
        #1;
        chk("arst_dout", 32'(dout), 32'h00);
        chk("arst_so", 32'(serial_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("arst_no_done", 32'(seen), 32'd0);
        chk("arst_hold", 32'(dout), 32'h00);

        run(LOAD, 3'd0, 8'h3C, 1'b0);
        chk("load_3c", 32'(dout), 32'h3C);
        chk("load_3c_done", 32'(done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_engine.md
# shift_engine

Parametrised sequential shift/rotate engine replacing the fixed 8-bit combinational shifter in the datapath. It holds a WIDTH-bit register and applies load, set, clear, logical/arithmetic shift and rotate operations, each with a programmable shift amount. Operations are requested with a start/busy/done handshake. By default a shift runs iteratively, one bit per clock; the barrel option completes it in one cycle.

## Interface
- WIDTH, 8, register width; minimum 2.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  operation request; sampled on a clk edge; ignored while busy=1.
- op  input  3  operation code, latched when start is accepted.
- amount  input  SHW  shift/rotate distance 0..WIDTH-1, latched with op.
- din  input  WIDTH  parallel load data.
- serial_in  input  1  fill bit for SHL.
- dout  output  WIDTH  register contents, always driven.
- serial_out  output  1  last bit shifted out by SHL, SHR or SAR.
- busy  output  1  multi-cycle shift in progress.
- done  output  1  one-cycle completion pulse.

## Operation
- Op codes:
  - 000 SET: reg = all ones.
  - 001 SHL: shift left; bit 0 filled with serial_in; serial_out = MSB shifted out.
  - 010 ROL: rotate left.
  - 011 SHR: logical shift right; 0 fill; serial_out = LSB shifted out.
  - 100 SAR: arithmetic shift right; MSB replicated; serial_out = LSB shifted out.
  - 101 ROR: rotate right.
  - 110 LOAD: reg = din.
  - 111 CLEAR: reg = 0.
- Operations act on the current register contents; only LOAD reads din.
- serial_out changes only on SHL, SHR and SAR with amount>0. It holds its value otherwise, including on rotates.
- States: IDLE, SHIFT.
  - IDLE, start=1, op is SET/LOAD/CLEAR: update reg; done=1; stay IDLE.
  - IDLE, start=1, shift/rotate op, amount=0: reg and serial_out unchanged; done=1.
  - IDLE, start=1, shift/rotate op, amount=N>0: perform the first bit step; cnt=N-1. If cnt=0, set done=1 and stay IDLE. Otherwise enter SHIFT with busy=1.
  - SHIFT: one bit step per edge; cnt decrements. On the edge that performs the last step: go to IDLE, busy=0, done=1.
- start while busy=1 is ignored. The request is lost, not queued.
- serial_in is sampled at each bit step. It must be held stable for the whole operation.

## Timing
- Reset values: dout=0, serial_out=0, busy=0, done=0, state=IDLE, cnt=0.
- rst asserted mid-operation aborts immediately. No done pulse is produced.
- Single-cycle ops: result on dout and done=1 after the accepting edge.
- Iterative shift, N>0: dout updates after every edge. The final value and done=1 appear after edge N-1 counted from the accepting edge (edge 0). busy is high after edges 0..N-2.
- done is high for exactly one cycle.
- start may be reasserted in the cycle done is high; it is accepted on that edge.

## Configuration
- Macro: SHIFT_ENGINE_BARREL_EN.
- Defined:
  - All shifts and rotates complete in one cycle via a barrel shifter; SHIFT state is unused; busy stays 0.
  - SHL fills all N low bits with serial_in.
  - serial_out equals the last bit that the iterative engine would shift out.
  - done=1 after the accepting edge.
- Undefined: iterative behaviour as described above.
- Final dout and serial_out values are identical in both builds.

## Test plan
- Reset: assert rst mid-test -> dout=0x00, serial_out=0, busy=0, done=0 with no clock edge required.
- LOAD 0xA5; then SHL amount=3, serial_in=1 -> dout=0x2F, serial_out=1. Iterative build: busy high for 2 cycles, done after the 3rd edge.
- LOAD 0x90; SAR amount=2 -> dout=0xE4, serial_out=0. Then SHR amount=4 -> dout=0x0E, serial_out=0.
- LOAD 0x81; ROR amount=1 -> 0xC0, serial_out unchanged. Then ROL amount=4 -> 0x0C.
- Start a SHL amount=7 and pulse start with CLEAR while busy -> CLEAR ignored; final dout is the shift result. Then amount=0 ROL -> dout unchanged, done after 1 edge.
- SET; then SHL amount=5 with rst asserted after 2 edges -> dout=0x00, no done pulse; next LOAD 0x3C works normally.
